call_return_sequencer: RTL and testbench

Program-counter sequencer for the simple microprocessor: it owns the PC and drives the push/pop side of the call stack. CALL pushes the return address and jumps. RET pops the stack and reloads the PC from the popped value. The block tracks call depth and traps on stack overflow or underflow.

---
 rtl/seq_pkg.sv | 19 +
 rtl/call_depth_counter.sv | 29 ++
 rtl/call_return_sequencer.sv | 117 +++++++++++
 tb/tb_call_return_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the call/return PC sequencer.
package seq_pkg;

  localparam int PC_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_SEQ  = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_POP  = 2'd1,
    RET_LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/call_depth_counter.sv
// Outstanding-CALL counter with full/empty flags.
module call_depth_counter #(
  parameter int DEPTH = 15
) (
  input  logic       nclk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [4:0] depth,
  output logic       at_max,
  output logic       at_zero
);

  localparam logic [4:0] MAX = 5'(DEPTH);

  always_ff @(negedge nclk or posedge reset) begin
    if (reset) begin
      depth <= '0;
    end else if (inc && !dec) begin
      depth <= depth + 5'd1;
    end else if (dec && !inc) begin
      depth <= depth - 5'd1;
    end
  end

  assign at_max  = (depth == MAX);
  assign at_zero = (depth == 5'd0);

endmodule

// File: rtl/call_return_sequencer.sv
// PC owner: SEQ/JUMP/CALL/RET sequencing with push/pop strobes
// to an external call stack and sticky overflow/underflow trap.
module call_return_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              DEPTH    = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            nclk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [1:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic            stall,
  input  logic [PC_W-1:0] stack_top,
  output logic            count_up,
  output logic            count_down,
  output logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic [4:0]      depth,
  output logic            fault
);

  localparam logic [PC_W-1:0] ONE = 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_d, pd_d;
  logic            up_d, dn_d, fault_d;
  logic            inc, dec, at_max, at_zero;
  logic            accept;

  call_depth_counter #(
    .DEPTH(DEPTH)
  ) u_depth (
    .nclk   (nclk),
    .reset  (reset),
    .inc    (inc),
    .dec    (dec),
    .depth  (depth),
    .at_max (at_max),
    .at_zero(at_zero)
  );

  assign accept = instr_valid & ~stall
                & (state_q == RUN) & ~fault;

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    pd_d    = push_data;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    fault_d = fault;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          unique case (op_e'(op))
            OP_SEQ:  pc_d = pc + ONE;
            OP_JUMP: pc_d = target;
            OP_CALL: begin
              if (at_max) begin
                fault_d = 1'b1;
              end else begin
                up_d = 1'b1;
                pd_d = pc + ONE;
                pc_d = target;
                inc  = 1'b1;
              end
            end
            OP_RET: begin
              if (at_zero) begin
                fault_d = 1'b1;
              end else begin
                dn_d    = 1'b1;
                dec     = 1'b1;
                state_d = RET_POP;
              end
            end
            default: pc_d = pc;
          endcase
        end
      end
      RET_POP:  state_d = RET_LOAD;
      // stack pointer has already stepped back, so top is the return address
      RET_LOAD: begin
        pc_d    = stack_top;
        state_d = RUN;
      end
      default:  state_d = RUN;
    endcase
  end

  always_ff @(negedge nclk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc         <= RESET_PC;
      push_data  <= '0;
      count_up   <= 1'b0;
      count_down <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      push_data  <= pd_d;
      count_up   <= up_d;
      count_down <= dn_d;
      fault      <= fault_d;
    end
  end

  assign busy = (state_q != RUN);

endmodule

// File: tb/tb_call_return_sequencer.sv
// Directed scoreboard bench for call_return_sequencer.
module tb_call_return_sequencer;

  logic       nclk = 1'b1;
  logic       reset;
  logic       instr_valid;
  logic [1:0] op;
  logic [7:0] target;
  logic       stall;
  logic [7:0] stack_top;
  logic       count_up, count_down, busy, fault;
  logic [7:0] push_data, pc;
  logic [4:0] depth;

  typedef struct {
    logic [7:0] pc;
    logic [4:0] depth;
    logic       up;
    logic       dn;
    logic       busy;
    logic       fault;
    logic [7:0] pd;
    logic       chk_pd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  logic [7:0] mem [16];
  logic [3:0] sp;

  always #5 nclk = ~nclk;

  call_return_sequencer dut (
    .nclk       (nclk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .op         (op),
    .target     (target),
    .stall      (stall),
    .stack_top  (stack_top),
    .count_up   (count_up),
    .count_down (count_down),
    .push_data  (push_data),
    .pc         (pc),
    .busy       (busy),
    .depth      (depth),
    .fault      (fault)
  );

  always @(negedge nclk or posedge reset) begin
    if (reset) begin
      sp <= 4'd0;
    end else if (count_up) begin
      mem[sp] <= push_data;
      sp      <= sp + 4'd1;
    end else if (count_down) begin
      sp <= sp - 4'd1;
    end
  end

  assign stack_top = mem[sp];

  function automatic exp_t mk(input logic [7:0] p,
                              input logic [4:0] d,
                              input logic u, input logic n,
                              input logic b, input logic f,
                              input logic [7:0] pd,
                              input logic cp);
    exp_t e;
    e.pc = p; e.depth = d; e.up = u; e.dn = n;
    e.busy = b; e.fault = f; e.pd = pd; e.chk_pd = cp;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] got,
                     input logic [7:0] want);
    vectors++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      fails++;
      $error("FAIL scoreboard: observed empty expected entry");
    end else begin
      e = sb.pop_front();
      cmp("pc", pc, e.pc);
      cmp("depth", {3'b0, depth}, {3'b0, e.depth});
      cmp("count_up", {7'b0, count_up}, {7'b0, e.up});
      cmp("count_down", {7'b0, count_down}, {7'b0, e.dn});
      cmp("busy", {7'b0, busy}, {7'b0, e.busy});
      cmp("fault", {7'b0, fault}, {7'b0, e.fault});
      if (e.chk_pd) cmp("push_data", push_data, e.pd);
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] o,
                       input logic [7:0] t, input logic s,
                       input exp_t e);
    instr_valid = v; op = o; target = t; stall = s;
    sb.push_back(e);
    @(posedge nclk);
    chk();
  endtask

  task automatic do_reset();
    instr_valid = 1'b0; op = 2'b00; target = 8'h00; stall = 1'b0;
    reset = 1'b1;
    sb.push_back(mk(8'h00, 0, 0, 0, 0, 0, 8'h00, 1));
    @(posedge nclk);
    chk();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0; op = 2'b00; target = 8'h00; stall = 1'b0;
    @(posedge nclk);
    do_reset();

    apply(1, 2'b00, 8'h00, 0, mk(8'h01, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h02, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h03, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h04, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h05, 0, 0, 0, 0, 0, 0, 0));

    apply(1, 2'b10, 8'h40, 0, mk(8'h40, 1, 1, 0, 0, 0, 8'h06, 1));
    apply(1, 2'b11, 8'h00, 0, mk(8'h40, 0, 0, 1, 1, 0, 0, 0));
    apply(0, 2'b00, 8'h00, 0, mk(8'h40, 0, 0, 0, 1, 0, 0, 0));
    apply(0, 2'b00, 8'h00, 0, mk(8'h06, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 15; i++) begin
      apply(1, 2'b10, 8'(8'h10 + i), 0,
            mk(8'(8'h10 + i), 5'(i + 1), 1, 0, 0, 0,
               (i == 0) ? 8'h07 : 8'(8'h10 + i), 1));
    end
    apply(1, 2'b10, 8'h80, 0, mk(8'h1E, 15, 0, 0, 0, 1, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h1E, 15, 0, 0, 0, 1, 0, 0));
    do_reset();

    apply(1, 2'b11, 8'h00, 0, mk(8'h00, 0, 0, 0, 0, 1, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h00, 0, 0, 0, 0, 1, 0, 0));
    do_reset();

    apply(1, 2'b01, 8'hFF, 0, mk(8'hFF, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 0, mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b01, 8'hFF, 0, mk(8'hFF, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 2'b00, 8'h00, 0, mk(8'hFF, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b10, 8'h20, 0, mk(8'h20, 1, 1, 0, 0, 0, 8'h00, 1));
    apply(1, 2'b11, 8'h00, 0, mk(8'h20, 0, 0, 1, 1, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 1, mk(8'h20, 0, 0, 0, 1, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 1, mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b00, 8'h00, 1, mk(8'h00, 0, 0, 0, 0, 0, 0, 0));

    apply(1, 2'b01, 8'h30, 0, mk(8'h30, 0, 0, 0, 0, 0, 0, 0));
    apply(1, 2'b10, 8'h50, 0, mk(8'h50, 1, 1, 0, 0, 0, 8'h31, 1));
    apply(1, 2'b11, 8'h00, 0, mk(8'h50, 0, 0, 1, 1, 0, 0, 0));
    apply(0, 2'b00, 8'h00, 0, mk(8'h50, 0, 0, 0, 1, 0, 0, 0));
    do_reset();
    apply(1, 2'b00, 8'h00, 0, mk(8'h01, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
